// File: rtl/history_reader_if.sv
// Stream/BRAM bundle for history_reader; clear_in exists only when
// HISTORY_READER_CLEAR_EN is defined.
interface history_reader_if #(
  parameter int COLOR_DEPTH = 8,
  parameter int NUM_PIXELS  = 57600
);
  logic                          frame_start_in;
  logic [$clog2(NUM_PIXELS)-1:0] mem_addr_out;
  logic                          mem_ren_out;
  logic [COLOR_DEPTH-1:0]        mem_data_in;
  logic [COLOR_DEPTH-1:0]        history_out;
  logic                          history_valid_out;
  logic                          history_ready_in;
  logic                          history_last_out;
  logic                          busy_out;
`ifdef HISTORY_READER_CLEAR_EN
  logic                          clear_in;
`endif

  modport master (
    input  frame_start_in, mem_data_in, history_ready_in,
`ifdef HISTORY_READER_CLEAR_EN
    input  clear_in,
`endif
    output mem_addr_out, mem_ren_out, history_out, history_valid_out,
    output history_last_out, busy_out
  );

  modport slave (
    output frame_start_in, mem_data_in, history_ready_in,
`ifdef HISTORY_READER_CLEAR_EN
    output clear_in,
`endif
    input  mem_addr_out, mem_ren_out, history_out, history_valid_out,
    input  history_last_out, busy_out
  );
endinterface

// File: rtl/history_reader.sv
// Raster-order history frame reader: credit-paced BRAM reads into a small return
// FIFO, streamed out valid/ready. Optional blanking frames via HISTORY_READER_CLEAR_EN.
module history_reader #(
  parameter int COLOR_DEPTH  = 8,
  parameter int NUM_PIXELS   = 57600,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input logic              clk_in,
  input logic              rst_in,
  history_reader_if.master bus
);
  localparam int ADDR_W = $clog2(NUM_PIXELS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W:0]    CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       addr;
  logic                    busy;
  logic [CNT_W-1:0]        in_flight;
  logic [CNT_W-1:0]        fifo_count;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [READ_LATENCY-1:0] vld_p;
  logic [READ_LATENCY-1:0] last_p;
  logic [COLOR_DEPTH-1:0]  fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last;
  logic [CNT_W:0]          credit_used;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [COLOR_DEPTH-1:0]  push_data;
`ifdef HISTORY_READER_CLEAR_EN
  logic                    clear_frame;
  logic [READ_LATENCY-1:0] clr_p;
`endif

  // Issue stage: one credit per read in flight or pixel buffered
  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign issue       = (state == FETCH) && (credit_used < CREDITS);
  assign fifo_empty  = (fifo_count == '0);
  assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign push        = vld_p[READ_LATENCY-1];
  assign pop         = !fifo_empty && bus.history_ready_in;

`ifdef HISTORY_READER_CLEAR_EN
  // A blanking frame still walks the credit/delay path, just without touching memory.
  assign bus.mem_ren_out = issue && !clear_frame;
  assign push_data       = clr_p[READ_LATENCY-1] ? '0 : bus.mem_data_in;
`else
  assign bus.mem_ren_out = issue;
  assign push_data       = bus.mem_data_in;
`endif

  assign bus.mem_addr_out      = addr;
  assign bus.busy_out          = busy;
  assign bus.history_valid_out = !fifo_empty;
  assign bus.history_out       = fifo_empty ? '0 : fifo_data[rd_ptr];
  assign bus.history_last_out  = !fifo_empty && fifo_last[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      addr       <= '0;
      busy       <= 1'b0;
      in_flight  <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      vld_p      <= '0;
`ifdef HISTORY_READER_CLEAR_EN
      clear_frame <= 1'b0;
`endif
    end else begin
      // Return stage: delay line mirrors the BRAM latency
      vld_p[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];

      in_flight  <= in_flight + CNT_W'(issue) - CNT_W'(push);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case (state)
        IDLE: begin
          if (bus.frame_start_in) begin
            state <= FETCH;
            addr  <= '0;
            busy  <= 1'b1;
`ifdef HISTORY_READER_CLEAR_EN
            clear_frame <= bus.clear_in;
`endif
          end
        end
        FETCH: begin
          if (issue) begin
            if (addr == LAST_ADDR) state <= DRAIN;
            else                   addr  <= addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Leave as the final beat is accepted so busy falls right after it.
          if (in_flight == '0 &&
              (fifo_empty || (fifo_count == CNT_W'(1) && pop))) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer stage: tags and pixel data, qualified by vld_p / fifo_count
  always_ff @(posedge clk_in) begin
    last_p[0] <= issue && (addr == LAST_ADDR);
    for (int i = 1; i < READ_LATENCY; i++) last_p[i] <= last_p[i-1];
`ifdef HISTORY_READER_CLEAR_EN
    clr_p[0] <= clear_frame;
    for (int i = 1; i < READ_LATENCY; i++) clr_p[i] <= clr_p[i-1];
`endif
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_last[wr_ptr] <= last_p[READ_LATENCY-1];
    end
  end

  a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
    !(push && !pop && fifo_full));

endmodule

// File: tb/tb_history_reader.sv
// Scoreboard bench for history_reader: small 16-pixel frame, BRAM model returning
// addr+8'h10 two cycles after each read; a negedge monitor checks every beat.
module tb_history_reader;
  localparam int CD = 8;
  localparam int NP = 16;
  localparam int RL = 2;
  localparam int FD = 4;

  typedef struct {
    logic [CD-1:0] d;
    logic          l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  history_reader_if #(.COLOR_DEPTH(CD), .NUM_PIXELS(NP)) bus();

  history_reader #(
    .COLOR_DEPTH (CD),
    .NUM_PIXELS  (NP),
    .READ_LATENCY(RL),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  // BRAM model: garbage (8'hEE) on cycles without a read
  logic [CD-1:0] bram_p [RL];
  always @(posedge clk) begin
    bram_p[0] <= bus.mem_ren_out ? (CD'(bus.mem_addr_out) + 8'h10) : 8'hEE;
    for (int i = 1; i < RL; i++) bram_p[i] <= bram_p[i-1];
  end
  assign bus.mem_data_in = bram_p[RL-1];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   beats, rens;
  int   start_cyc, first_beat_cyc, last_beat_cyc, first_ren_cyc, last_ren_cyc;
  int   issued_total, accepted_total;
  int   ready_mode = 0;
  int   ready_k = 0;
  logic check_busy_next = 1'b0;
  logic stall_prev = 1'b0;
  logic [CD-1:0] stall_data;
  logic [3:0] ready_pat = 4'b1001;
  exp_t exp_q[$];
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = repeating 1,0,0,1, 2 = never ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          bus.history_ready_in = ready_pat[3 - (ready_k % 4)];
          ready_k++;
        end
        2:       bus.history_ready_in = 1'b0;
        default: bus.history_ready_in = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b0) begin
        stall_prev      = 1'b0;
        check_busy_next = 1'b0;
      end else begin
        if (bus.frame_start_in && !bus.busy_out) start_cyc = cyc;
        if (check_busy_next) begin
          check("busy_drop", bus.busy_out, 0);
          check_busy_next = 1'b0;
        end
        if (stall_prev) begin
          check("stall_valid", bus.history_valid_out, 1);
          check("stall_hold", bus.history_out, stall_data);
        end
        if (bus.mem_ren_out) begin
          check("addr", bus.mem_addr_out, rens);
          issued_total++;
          check("credit", (issued_total - accepted_total) <= FD, 1);
          if (rens == 0) first_ren_cyc = cyc;
          last_ren_cyc = cyc;
          rens++;
        end
        if (bus.history_valid_out && bus.history_ready_in) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_beat: got %0h expected no beat", bus.history_out);
          end else begin
            e = exp_q.pop_front();
            check("data", bus.history_out, e.d);
            check("last", bus.history_last_out, e.l);
          end
          if (bus.history_last_out) begin
            check("busy_at_last", bus.busy_out, 1);
            check_busy_next = 1'b1;
          end
          if (beats == 0) first_beat_cyc = cyc;
          last_beat_cyc = cyc;
          beats++;
          accepted_total++;
        end
        stall_prev = bus.history_valid_out && !bus.history_ready_in;
        stall_data = bus.history_out;
      end
    end
  end

  task automatic start_frame(input logic clr);
    for (int i = 0; i < NP; i++) begin
      exp_t x;
      x.d = clr ? 8'h00 : CD'(i + 16);
      x.l = (i == NP - 1);
      exp_q.push_back(x);
    end
    beats = 0;
    rens  = 0;
    bus.frame_start_in = 1'b1;
`ifdef HISTORY_READER_CLEAR_EN
    bus.clear_in = clr;
`endif
    @(posedge clk);
    #1;
    bus.frame_start_in = 1'b0;
`ifdef HISTORY_READER_CLEAR_EN
    bus.clear_in = 1'b0;
`endif
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bus.busy_out || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frame_done", (n < budget) ? 0 : 1, 0);
    check("beats", beats, NP);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("beat_wait", (n < 200) ? 0 : 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1);
  end

  initial begin
    logic acc;
    rst = 1'b1;
    bus.frame_start_in = 1'b0;
`ifdef HISTORY_READER_CLEAR_EN
    bus.clear_in = 1'b0;
`endif
    beats = 0;
    rens = 0;
    issued_total = 0;
    accepted_total = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and quiet idle
    check("rst_ren", bus.mem_ren_out, 0);
    check("rst_addr", bus.mem_addr_out, 0);
    check("rst_valid", bus.history_valid_out, 0);
    check("rst_last", bus.history_last_out, 0);
    check("rst_out", bus.history_out, 0);
    check("rst_busy", bus.busy_out, 0);
    acc = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      acc = acc | bus.mem_ren_out | bus.history_valid_out | bus.busy_out;
    end
    check("idle_quiet", acc, 0);

    // Full-rate frame
    ready_mode = 0;
    start_frame(1'b0);
    wait_idle(100);
    check("ren_count", rens, NP);
    check("ren_span", last_ren_cyc - first_ren_cyc, NP - 1);
    check("beat_span", last_beat_cyc - first_beat_cyc, NP - 1);
    check("latency", (first_beat_cyc - start_cyc) >= RL + 2, 1);

    // Ready toggling 1,0,0,1
    ready_mode = 1;
    ready_k = 0;
    @(posedge clk);
    #1;
    start_frame(1'b0);
    wait_idle(300);
    check("ren_count_toggle", rens, NP);

    // Consumer stalled for 100 cycles
    ready_mode = 2;
    @(posedge clk);
    #1;
    start_frame(1'b0);
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    check("stall_ren_count", rens, FD);
    check("stall_full_valid", bus.history_valid_out, 1);
    ready_mode = 0;
    wait_idle(100);
    check("ren_count_stall", rens, NP);

    // Restart pulse mid-frame is ignored
    start_frame(1'b0);
    wait_beats(5);
    bus.frame_start_in = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_start_in = 1'b0;
    wait_idle(100);
    check("ren_count_restart", rens, NP);
    repeat (5) @(posedge clk);
    #1;
    check("restart_idle_busy", bus.busy_out, 0);

    // Reset mid-frame
    start_frame(1'b0);
    wait_beats(9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ren", bus.mem_ren_out, 0);
    check("mid_rst_addr", bus.mem_addr_out, 0);
    check("mid_rst_valid", bus.history_valid_out, 0);
    check("mid_rst_last", bus.history_last_out, 0);
    check("mid_rst_out", bus.history_out, 0);
    check("mid_rst_busy", bus.busy_out, 0);
    exp_q.delete();
    issued_total = 0;
    accepted_total = 0;
    rst = 1'b0;
    acc = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      acc = acc | bus.history_valid_out | bus.mem_ren_out;
    end
    check("no_stale", acc, 0);

    // Clean frame after reset
    start_frame(1'b0);
    wait_idle(100);
    check("ren_count_after_rst", rens, NP);

`ifdef HISTORY_READER_CLEAR_EN
    // Blanking frame: zeros, no memory reads
    start_frame(1'b1);
    wait_idle(100);
    check("clear_ren_count", rens, 0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
